// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Definitions shared by the I2S capture (audio_receiver) and playback paths.
//   DATA_W          : sample width, 16 sclk slots per channel
//   DIV_W           : width of the free-running frame divider
//   MCLK/SCLK/LRCLK_BIT : divider bits that become the I2S clocks
//   stereo_t        : one left/right sample pair
//   abs_mag()       : unsigned magnitude of a signed sample (|-32768| = 32768)
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int DATA_W    = 16;
    localparam int DIV_W     = 9;
    localparam int MCLK_BIT  = 1;
    localparam int SCLK_BIT  = 3;
    localparam int LRCLK_BIT = 8;

    typedef struct packed {
        logic [DATA_W-1:0] left;
        logic [DATA_W-1:0] right;
    } stereo_t;

    // Two's-complement magnitude as an unsigned value; the most negative
    // sample maps to 2^(DATA_W-1) without saturation.
    function automatic logic [DATA_W-1:0] abs_mag(input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] neg;
        neg = (~s) + DATA_W'(1);
        return s[DATA_W-1] ? neg : s;
    endfunction

endpackage

// File: rtl/audio_clk_gen.sv
// -----------------------------------------------------------------------------
// audio_clk_gen
// Free-running 9-bit frame divider plus registered I2S clocks. Each clock
// output equals its divider bit in the same cycle (registered from the next
// count), so lrclk falls exactly when div_cnt wraps to 0.
// Ports:
//   clk     : system clock
//   rst     : asynchronous active-low reset (all outputs to 0)
//   div_cnt : current divider value, 0..511
//   mclk    : div_cnt[1]  (clk/4)
//   sclk    : div_cnt[3]  (clk/16)
//   lrclk   : div_cnt[8]  (clk/512, 0 = left)
// -----------------------------------------------------------------------------
module audio_clk_gen
    import audio_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    output logic [DIV_W-1:0] div_cnt,
    output logic             mclk,
    output logic             sclk,
    output logic             lrclk
);

    logic [DIV_W-1:0] div_cnt_reg;
    logic [DIV_W-1:0] div_cnt_next;
    logic             mclk_reg;
    logic             sclk_reg;
    logic             lrclk_reg;

    assign div_cnt_next = div_cnt_reg + DIV_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_reg <= '0;
            mclk_reg    <= 1'b0;
            sclk_reg    <= 1'b0;
            lrclk_reg   <= 1'b0;
        end else begin
            div_cnt_reg <= div_cnt_next;
            mclk_reg    <= div_cnt_next[MCLK_BIT];
            sclk_reg    <= div_cnt_next[SCLK_BIT];
            lrclk_reg   <= div_cnt_next[LRCLK_BIT];
        end
    end

    assign div_cnt = div_cnt_reg;
    assign mclk    = mclk_reg;
    assign sclk    = sclk_reg;
    assign lrclk   = lrclk_reg;

endmodule

// File: rtl/audio_receiver.sv
// -----------------------------------------------------------------------------
// audio_receiver
// I2S capture for a 16-bit stereo ADC. Generates mclk/sclk/lrclk from clk,
// deserialises audio_sdout (one-bit I2S delay) and hands each completed
// stereo pair to a one-entry valid/ready buffer.
// Ports:
//   clk          : system clock (100 MHz)
//   rst          : asynchronous active-low reset
//   audio_mclk   : ADC master clock, clk/4
//   audio_lrclk  : word select, 0 = left, clk/512
//   audio_sclk   : bit clock, clk/16
//   audio_sdout  : serial data from the ADC
//   audio_left   : signed left sample of the held pair
//   audio_right  : signed right sample of the held pair
//   sample_valid : a pair is held
//   sample_ready : consumer takes the pair when valid && ready
//   overrun      : sticky, a completed pair was dropped (cleared by reset)
// Optional (macro AUDIO_RX_PEAK_EN):
//   peak_clr     : zeroes both peak meters (wins over a simultaneous update)
//   peak_left    : max |left| over accepted pairs, unsigned
//   peak_right   : max |right| over accepted pairs, unsigned
// -----------------------------------------------------------------------------
module audio_receiver #(
    parameter int SAMPLE_PHASE = 12,
    parameter int DATA_W       = audio_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              audio_mclk,
    output logic              audio_lrclk,
    output logic              audio_sclk,
    input  logic              audio_sdout,
    output logic [DATA_W-1:0] audio_left,
    output logic [DATA_W-1:0] audio_right,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun
`ifdef AUDIO_RX_PEAK_EN
    ,
    input  logic              peak_clr,
    output logic [DATA_W-1:0] peak_left,
    output logic [DATA_W-1:0] peak_right
`endif
);

    import audio_pkg::*;

    logic [DIV_W-1:0]  div_cnt;
    logic              sd_q_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] word_next;
    logic [DATA_W-1:0] left_hold_reg;
    logic              primed_reg;
    logic              primed_next;
    // msb_primed_reg[c]: primed was set when channel c's current word MSB
    // (slot 1) was captured, so that word may be delivered.
    logic [1:0]        msb_primed_reg;
    stereo_t           pair_reg;
    logic              sample_valid_reg;
    logic              overrun_reg;

    logic              capture;
    logic [3:0]        slot;
    logic              chan;
    logic              left_done;
    logic              pair_done;

    audio_clk_gen u_clk_gen (
        .clk     (clk),
        .rst     (rst),
        .div_cnt (div_cnt),
        .mclk    (audio_mclk),
        .sclk    (audio_sclk),
        .lrclk   (audio_lrclk)
    );

    assign capture   = (div_cnt[3:0] == 4'(SAMPLE_PHASE));
    assign slot      = div_cnt[7:4];
    assign chan      = div_cnt[8];
    assign word_next = {shift_reg[DATA_W-2:0], sd_q_reg};

    assign primed_next = primed_reg | (capture && (slot == 4'd1) && !chan);

    // One-bit I2S delay: the LSB of a word arrives in slot 0 of the other
    // half, so the left word completes in the right half and vice versa.
    assign left_done = capture && (slot == 4'd0) &&  chan && msb_primed_reg[0];
    assign pair_done = capture && (slot == 4'd0) && !chan && msb_primed_reg[1];

    // Deserialiser and priming.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sd_q_reg       <= 1'b0;
            shift_reg      <= '0;
            left_hold_reg  <= '0;
            primed_reg     <= 1'b0;
            msb_primed_reg <= 2'b00;
        end else begin
            sd_q_reg   <= audio_sdout;
            primed_reg <= primed_next;
            if (capture) begin
                shift_reg <= word_next;
            end
            if (capture && (slot == 4'd1)) begin
                msb_primed_reg[chan] <= primed_next;
            end
            if (left_done) begin
                left_hold_reg <= word_next;
            end
        end
    end

    // One-entry output buffer. A pair completing while the consumer is
    // draining the previous one replaces it without a gap in valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pair_reg         <= '0;
            sample_valid_reg <= 1'b0;
            overrun_reg      <= 1'b0;
        end else if (pair_done) begin
            if (!sample_valid_reg || sample_ready) begin
                pair_reg.left    <= left_hold_reg;
                pair_reg.right   <= word_next;
                sample_valid_reg <= 1'b1;
            end else begin
                overrun_reg <= 1'b1;
            end
        end else if (sample_valid_reg && sample_ready) begin
            sample_valid_reg <= 1'b0;
        end
    end

    assign audio_left   = pair_reg.left;
    assign audio_right  = pair_reg.right;
    assign sample_valid = sample_valid_reg;
    assign overrun      = overrun_reg;

`ifdef AUDIO_RX_PEAK_EN
    logic              accept;
    logic [DATA_W-1:0] chan_sample [2];

    assign accept         = sample_valid_reg && sample_ready;
    assign chan_sample[0] = pair_reg.left;
    assign chan_sample[1] = pair_reg.right;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_peak
            logic [DATA_W-1:0] mag;
            logic [DATA_W-1:0] peak_reg;

            assign mag = abs_mag(chan_sample[gi]);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    peak_reg <= '0;
                end else if (peak_clr) begin
                    peak_reg <= '0;
                end else if (accept && (mag > peak_reg)) begin
                    peak_reg <= mag;
                end
            end
        end
    endgenerate

    assign peak_left  = g_peak[0].peak_reg;
    assign peak_right = g_peak[1].peak_reg;
`endif

endmodule
